// File: rtl/cnn_frame_scheduler_if.sv
// Pixel, classifier and status bundle of the CNN frame scheduler.
// The master side is the host (ROI sampler / classifier); the slave side is the scheduler.
interface cnn_frame_scheduler_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  en;
   logic                  vsync;
   logic                  pix_valid_in;
   logic [DATA_WIDTH-1:0] pix_in;
   logic                  cnn_valid_out;
   logic [DATA_WIDTH-1:0] cnn_pixel_out;
   logic                  class_valid;
   logic signed [31:0]    score0;
   logic signed [31:0]    score1;
   logic signed [31:0]    score2;
   logic [2:0]            shape_code;
   logic                  shape_valid;
   logic                  busy;
   logic                  timeout_err;
   logic                  pad_err;

   modport master (
      output en, vsync, pix_valid_in, pix_in,
      output class_valid, score0, score1, score2,
      input  cnn_valid_out, cnn_pixel_out,
      input  shape_code, shape_valid, busy, timeout_err, pad_err
   );

   modport slave (
      input  en, vsync, pix_valid_in, pix_in,
      input  class_valid, score0, score1, score2,
      output cnn_valid_out, cnn_pixel_out,
      output shape_code, shape_valid, busy, timeout_err, pad_err
   );
endinterface

// File: rtl/cnn_frame_scheduler.sv
// Frame sequencer: admits a fixed pixel count per frame, zero-pads short
// frames, waits for the classifier with a timeout and votes over frames.
module cnn_frame_scheduler #(
   parameter int DATA_WIDTH    = 8,
   parameter int PIX_PER_FRAME = 784,
   parameter int VOTE_FRAMES   = 8,
   parameter int TIMEOUT       = 4096
) (
   input logic                   clk,
   input logic                   rst_n,
   cnn_frame_scheduler_if.slave  sched
);
   localparam int PC_W = $clog2(PIX_PER_FRAME + 1);
   localparam int TC_W = $clog2(TIMEOUT + 1);
   localparam int VC_W = $clog2(VOTE_FRAMES + 1);

   localparam logic [PC_W-1:0] PIX_LAST = PC_W'(PIX_PER_FRAME - 1);
   localparam logic [TC_W-1:0] TMO_LAST = TC_W'(TIMEOUT - 1);
   localparam logic [VC_W-1:0] VOTE_MAX = VC_W'(VOTE_FRAMES);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_FEED, S_PAD, S_DRAIN, S_VOTE
   } state_t;

   state_t                r_state;
   logic                  r_vsync_q;
   logic [PC_W-1:0]       r_pix_cnt;
   logic [TC_W-1:0]       r_tmo_cnt;
   logic [VC_W-1:0]       r_frame_cnt;
   logic [VC_W-1:0]       r_vote_o;
   logic [VC_W-1:0]       r_vote_w;
   logic [VC_W-1:0]       r_vote_i;
   logic                  r_padded;
   logic [1:0]            r_win;
   logic                  r_cnn_valid;
   logic [DATA_WIDTH-1:0] r_cnn_pixel;
   logic [2:0]            r_shape_code;
   logic                  r_shape_valid;
   logic                  r_tmo_err;
   logic                  r_pad_err;

   logic                  w_vs_rise;
   logic [1:0]            w_win;
   logic [VC_W-1:0]       w_vote_o;
   logic [VC_W-1:0]       w_vote_w;
   logic [VC_W-1:0]       w_vote_i;
   logic [VC_W-1:0]       w_frame_nx;
   logic [2:0]            w_code;

   assign w_vs_rise = sched.vsync & ~r_vsync_q;

   // Argmax of the live scores; ties resolve toward the lower index.
   always_comb begin
      w_win = 2'd0;
      if (!(sched.score0 >= sched.score1 && sched.score0 >= sched.score2))
         w_win = (sched.score1 >= sched.score2) ? 2'd1 : 2'd2;
   end

   always_comb begin
      w_vote_o = r_vote_o;
      w_vote_w = r_vote_w;
      w_vote_i = r_vote_i;
      if (!r_padded) begin
         if (r_win == 2'd0 && r_vote_o != VOTE_MAX) w_vote_o = r_vote_o + 1'b1;
         if (r_win == 2'd1 && r_vote_w != VOTE_MAX) w_vote_w = r_vote_w + 1'b1;
         if (r_win == 2'd2 && r_vote_i != VOTE_MAX) w_vote_i = r_vote_i + 1'b1;
      end
      w_frame_nx = (r_frame_cnt == VOTE_MAX) ? r_frame_cnt : r_frame_cnt + 1'b1;
   end

   // Decision uses the counts including the frame being voted this cycle.
   always_comb begin
      w_code = 3'd0;
      if (w_vote_o != '0 || w_vote_w != '0 || w_vote_i != '0) begin
         if (w_vote_o >= w_vote_w && w_vote_o >= w_vote_i) w_code = 3'd1;
         else if (w_vote_w >= w_vote_i)                     w_code = 3'd2;
         else                                               w_code = 3'd3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_vsync_q     <= 1'b0;
         r_pix_cnt     <= '0;
         r_tmo_cnt     <= '0;
         r_frame_cnt   <= '0;
         r_vote_o      <= '0;
         r_vote_w      <= '0;
         r_vote_i      <= '0;
         r_padded      <= 1'b0;
         r_win         <= 2'd0;
         r_cnn_valid   <= 1'b0;
         r_cnn_pixel   <= '0;
         r_shape_code  <= 3'd0;
         r_shape_valid <= 1'b0;
         r_tmo_err     <= 1'b0;
         r_pad_err     <= 1'b0;
      end else begin
         r_vsync_q     <= sched.vsync;
         r_cnn_valid   <= 1'b0;
         r_cnn_pixel   <= '0;
         r_shape_valid <= 1'b0;
         r_tmo_err     <= 1'b0;
         r_pad_err     <= 1'b0;
         if (!sched.en) begin
            r_state     <= S_IDLE;
            r_pix_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_frame_cnt <= '0;
            r_vote_o    <= '0;
            r_vote_w    <= '0;
            r_vote_i    <= '0;
            r_padded    <= 1'b0;
         end else begin
            unique case (r_state)
               S_IDLE: r_state <= S_ARM;
               S_ARM: begin
                  if (w_vs_rise) begin
                     r_state   <= S_FEED;
                     r_pix_cnt <= '0;
                     r_padded  <= 1'b0;
                  end
               end
               S_FEED: begin
                  if (sched.pix_valid_in) begin
                     r_cnn_valid <= 1'b1;
                     r_cnn_pixel <= sched.pix_in;
                     r_pix_cnt   <= r_pix_cnt + 1'b1;
                  end
                  // A pixel that completes the frame wins over a same-cycle vsync.
                  if (sched.pix_valid_in && r_pix_cnt == PIX_LAST) begin
                     r_state   <= S_DRAIN;
                     r_tmo_cnt <= '0;
                  end else if (w_vs_rise) begin
                     r_state   <= S_PAD;
                     r_pad_err <= 1'b1;
                     r_padded  <= 1'b1;
                  end
               end
               S_PAD: begin
                  r_cnn_valid <= 1'b1;
                  r_pix_cnt   <= r_pix_cnt + 1'b1;
                  if (r_pix_cnt == PIX_LAST) begin
                     r_state   <= S_DRAIN;
                     r_tmo_cnt <= '0;
                  end
               end
               S_DRAIN: begin
                  if (sched.class_valid) begin
                     r_state <= S_VOTE;
                     r_win   <= w_win;
                  end else if (r_tmo_cnt == TMO_LAST) begin
                     r_state   <= S_ARM;
                     r_tmo_err <= 1'b1;
                  end else begin
                     r_tmo_cnt <= r_tmo_cnt + 1'b1;
                  end
               end
               S_VOTE: begin
                  r_state <= S_ARM;
                  if (w_frame_nx == VOTE_MAX) begin
                     r_shape_code  <= w_code;
                     r_shape_valid <= 1'b1;
                     r_frame_cnt   <= '0;
                     r_vote_o      <= '0;
                     r_vote_w      <= '0;
                     r_vote_i      <= '0;
                  end else begin
                     r_frame_cnt <= w_frame_nx;
                     r_vote_o    <= w_vote_o;
                     r_vote_w    <= w_vote_w;
                     r_vote_i    <= w_vote_i;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign sched.cnn_valid_out = r_cnn_valid;
   assign sched.cnn_pixel_out = r_cnn_pixel;
   assign sched.shape_code    = r_shape_code;
   assign sched.shape_valid   = r_shape_valid;
   assign sched.timeout_err   = r_tmo_err;
   assign sched.pad_err       = r_pad_err;
   assign sched.busy          = (r_state == S_FEED) || (r_state == S_PAD) ||
                                (r_state == S_DRAIN);
endmodule

// File: tb/tb_cnn_frame_scheduler.sv
// Randomized bench for cnn_frame_scheduler against a frame-level
// model of pixel admission, padding, timeouts and vote decisions.
module tb_cnn_frame_scheduler;
   localparam int DW  = 8;
   localparam int PPF = 16;
   localparam int VF  = 3;
   localparam int TMO = 50;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cnn_frame_scheduler_if #(.DATA_WIDTH(DW)) sif();

   cnn_frame_scheduler #(
      .DATA_WIDTH(DW), .PIX_PER_FRAME(PPF),
      .VOTE_FRAMES(VF), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sched(sif)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Output monitor
   int cyc = 0;
   logic [DW-1:0] got_q[$];
   int gotc_q[$];
   int n_sv = 0, n_pe = 0, n_te = 0;
   int te_cyc = 0, last_pix_cyc = 0, nz_bad = 0;

   always @(negedge clk) begin
      cyc++;
      if (sif.cnn_valid_out) begin
         got_q.push_back(sif.cnn_pixel_out);
         gotc_q.push_back(cyc);
         last_pix_cyc = cyc;
      end else if (sif.cnn_pixel_out != '0) begin
         nz_bad++;
      end
      if (sif.shape_valid) n_sv++;
      if (sif.pad_err) n_pe++;
      if (sif.timeout_err) begin
         n_te++;
         te_cyc = cyc;
      end
   end

   // Reference model state
   int mv[3];
   int mframes = 0, mcode = 0, m_sv = 0, m_pe = 0, m_te = 0;

   function automatic int argmax3(input int a, input int b, input int c);
      if (a >= b && a >= c) return 0;
      if (b >= c) return 1;
      return 2;
   endfunction

   function automatic int decide();
      if (mv[0] == 0 && mv[1] == 0 && mv[2] == 0) return 0;
      return argmax3(mv[0], mv[1], mv[2]) + 1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic vs_pulse();
      sif.vsync = 1'b1;
      step();
      sif.vsync = 1'b0;
   endtask

   task automatic send_pixels(input int n, input bit vs_last,
                              output logic [DW-1:0] sent[$]);
      logic [DW-1:0] v;
      sent.delete();
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) step();
         v = DW'($urandom);
         sif.pix_valid_in = 1'b1;
         sif.pix_in = v;
         sent.push_back(v);
         if (vs_last && i == n - 1) sif.vsync = 1'b1;
         step();
         sif.pix_valid_in = 1'b0;
         sif.vsync = 1'b0;
      end
   endtask

   task automatic run_frame(input int n, input bit give,
                            input int s0, input int s1, input int s2,
                            input bit vs_last_in);
      logic [DW-1:0] sent[$];
      logic [DW-1:0] exp_q[$];
      int wn, bad, badc;
      bit vs_last;
      vs_last = vs_last_in && n >= 2 && n < PPF;
      got_q.delete();
      gotc_q.delete();
      step();
      step();
      // junk pixel during the arming vsync must be ignored
      sif.pix_valid_in = 1'b1;
      sif.pix_in = 8'hA5;
      vs_pulse();
      sif.pix_valid_in = 1'b0;
      send_pixels(n, vs_last, sent);
      if (n < PPF && !vs_last) begin
         step();
         vs_pulse();
      end
      for (int i = 0; i < PPF; i++)
         exp_q.push_back(i < n ? sent[i] : '0);
      wn = 0;
      while (got_q.size() < PPF && wn < 200) begin
         step();
         wn++;
      end
      step();
      chk("pix_count", got_q.size(), PPF);
      chk("busy_drain", sif.busy, 1);
      bad = 0;
      for (int i = 0; i < PPF && i < got_q.size(); i++)
         if (got_q[i] !== exp_q[i]) bad++;
      chk("pix_data", bad, 0);
      if (n < PPF) begin
         badc = 0;
         for (int i = n + 1; i < PPF && i < gotc_q.size(); i++)
            if (gotc_q[i] - gotc_q[i-1] != 1) badc++;
         chk("pad_consec", badc, 0);
         m_pe++;
      end
      chk("pad_err_cnt", n_pe, m_pe);
      if (give) begin
         repeat ($urandom_range(0, 8)) step();
         sif.class_valid = 1'b1;
         sif.score0 = s0;
         sif.score1 = s1;
         sif.score2 = s2;
         step();
         sif.class_valid = 1'b0;
         mframes++;
         if (n >= PPF) mv[argmax3(s0, s1, s2)]++;
         if (mframes == VF) begin
            mcode = decide();
            m_sv++;
            mv = '{0, 0, 0};
            mframes = 0;
         end
      end else begin
         wn = 0;
         while (n_te == m_te && wn < TMO + 40) begin
            step();
            wn++;
         end
         m_te++;
         chk("tmo_cnt", n_te, m_te);
         chk("tmo_gap", te_cyc - last_pix_cyc, TMO);
         step();
         sif.class_valid = 1'b1;
         sif.score0 = s0;
         sif.score1 = s1;
         sif.score2 = s2;
         step();
         sif.class_valid = 1'b0;
      end
      repeat (3) step();
      chk("busy_after", sif.busy, 0);
      chk("sv_cnt", n_sv, m_sv);
      chk("shape_code", sif.shape_code, mcode);
      chk("nz_idle", nz_bad, 0);
   endtask

   task automatic abort_frame();
      logic [DW-1:0] sent[$];
      got_q.delete();
      step();
      step();
      vs_pulse();
      send_pixels(7, 1'b0, sent);
      sif.en = 1'b0;
      step();
      step();
      chk("abort_busy", sif.busy, 0);
      chk("abort_valid", sif.cnn_valid_out, 0);
      chk("abort_fwd", got_q.size(), 7);
      chk("abort_code", sif.shape_code, mcode);
      mv = '{0, 0, 0};
      mframes = 0;
      sif.en = 1'b1;
      step();
   endtask

   task automatic reset_mid_pad();
      logic [DW-1:0] sent[$];
      int wn, cnt;
      got_q.delete();
      step();
      step();
      vs_pulse();
      send_pixels(5, 1'b0, sent);
      step();
      vs_pulse();
      wn = 0;
      while (got_q.size() < 8 && wn < 50) begin
         step();
         wn++;
      end
      chk("rst_pad_seen", got_q.size(), 8);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", sif.cnn_valid_out, 0);
      chk("rst_busy", sif.busy, 0);
      chk("rst_code", sif.shape_code, 0);
      chk("rst_sv", sif.shape_valid, 0);
      chk("rst_perr", sif.pad_err, 0);
      cnt = got_q.size();
      repeat (3) step();
      rst_n = 1'b1;
      repeat (20) step();
      chk("rst_no_valid", got_q.size() - cnt, 0);
      chk("rst_idle_busy", sif.busy, 0);
   endtask

   initial begin
      int n;
      sif.en = 1'b0;
      sif.vsync = 1'b0;
      sif.pix_valid_in = 1'b0;
      sif.pix_in = '0;
      sif.class_valid = 1'b0;
      sif.score0 = 0;
      sif.score1 = 0;
      sif.score2 = 0;
      mv = '{0, 0, 0};
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", sif.cnn_valid_out, 0);
      chk("reset_pixel", sif.cnn_pixel_out, 0);
      chk("reset_code", sif.shape_code, 0);
      chk("reset_sv", sif.shape_valid, 0);
      chk("reset_busy", sif.busy, 0);
      chk("reset_tmo", sif.timeout_err, 0);
      chk("reset_perr", sif.pad_err, 0);
      rst_n = 1'b1;
      step();
      sif.en = 1'b1;
      step();

      run_frame(20, 1, 9, 3, 1, 0);
      run_frame(10, 1, 4, 8, 2, 1);
      run_frame(16, 1, 1, 9, 2, 0);
      run_frame(16, 1, 9, 1, 1, 0);
      run_frame(18, 1, 0, 7, 3, 0);
      run_frame(16, 1, -5, 8, 8, 0);
      run_frame(16, 1, 5, 5, 1, 0);
      run_frame(16, 0, 0, 9, 0, 0);
      abort_frame();
      run_frame(16, 1, 1, 2, 9, 0);

      for (int k = 0; k < 12; k++) begin
         n = $urandom_range(0, 20);
         run_frame(n, $urandom_range(0, 5) != 0,
                   int'($urandom_range(0, 20)) - 10,
                   int'($urandom_range(0, 20)) - 10,
                   int'($urandom_range(0, 20)) - 10,
                   1'($urandom_range(0, 1)));
      end

      reset_mid_pad();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
